msg_scroller: RTL and testbench
===============================

# msg_scroller

Upstream feeder for the 8-digit seven-segment display driver. Accepts a message of up to MSG_LEN 5-bit character codes through a valid/ready load handshake and produces the 40-bit `instruction` window consumed by the display stage. Messages of 8 characters or fewer are shown statically. Longer messages hold briefly, then scroll left one character per step, with 8 blanks between repeats. The block replaces the derived slow clock with a clock-enable tick on `clk`.

## Interface
Parameters:
- MSG_LEN, default 16 — maximum message length in characters (range 8–31).
- TICK_DIV, default 50_000_000 — `clk` cycles per scroll step (range ≥2).
- HOLD_STEPS, default 2 — steps the first window is held before scrolling starts (range ≥1).

Ports:
- clk  in  1 — system clock; single clock domain.
- rst_n  in  1 — reset, asynchronous, active-low.
- msg_in  in  5*MSG_LEN — message characters; char i occupies bits [5i+4:5i]; char 0 is first, i.e. leftmost.
- msg_len  in  5 — number of valid characters, 0..MSG_LEN; larger values saturate to MSG_LEN.
- load_valid  in  1 — load request; msg_in and msg_len are sampled when load_valid & load_ready.
- load_ready  out  1 — low only during the LOAD cycle.
- instruction  out  40 — display window; bits [39:35] are the leftmost digit (AN[7]), bits [4:0] the rightmost (AN[0]).
- busy  out  1 — high in HOLD and SCROLL.
- wrap  out  1 — one-cycle pulse when the scroll position returns to 0.

## Operation
- States and transitions:
  - IDLE: reached from reset or a length-0 load. Shows all blanks. Goes to LOAD on a handshake.
  - LOAD: lasts 1 cycle. Latches the message into the internal buffer, clears position p, clears the tick counter and clears the hold count.
    - len=0 → IDLE.
    - len≤8 → STATIC.
    - len>8 → HOLD.
  - STATIC: shows chars 0..len-1 left-justified, with blanks to the right. Stays until the next load.
  - HOLD: shows window p=0. Moves to SCROLL after HOLD_STEPS ticks.
  - SCROLL: on each tick, p ← (p+1) mod L, where L = len+8. On the tick that sets p to 0, pulse `wrap` and go back to HOLD.
- Window content: digit k (k=0 leftmost) shows S[(p+k) mod L]. S is the virtual stream: message chars followed by 8 CHAR_BLANK. Positions beyond len in the buffer are never displayed.
- Load rules:
  - A handshake is accepted in any state except LOAD.
  - A new load aborts the current scroll immediately; no old-window frames appear after LOAD.
- Tick counter: counts 0..TICK_DIV-1 and emits a 1-cycle tick at TICK_DIV-1. It free-runs except that LOAD clears it. Ticks are ignored in IDLE and STATIC.
- Width rules: p and L are 6 bits. The modulo is done by compare-and-subtract; no divider.

## Timing
- Reset values:
  - instruction = all CHAR_BLANK (40'hFFFF_FFFF_FF)
  - load_ready = 1
  - busy = 0
  - wrap = 0
  - state = IDLE
  - p = 0
  - tick counter = 0
- `instruction` is registered and updates one cycle after the tick or state change that causes it.
- Handshake in cycle N → LOAD in cycle N+1 (load_ready=0) → first window visible on `instruction` at N+2.
- First scroll step occurs HOLD_STEPS×TICK_DIV cycles after LOAD, then once every TICK_DIV cycles.
- `wrap` asserts in the same cycle that `instruction` shows window 0 again.
- Reset asserted mid-scroll forces all outputs to their reset values asynchronously. The buffer contents are don't-care.

## Structure
- Shared package `disp_pkg` holds:
  - CHAR_W=5
  - NUM_DIGITS=8
  - CHAR_BLANK=5'h1F
  - digit codes 0–9 = 5'd0–5'd9
  - the state enum
- The display driver imports the same package.
- One sub-module, `scroll_tick`: a parameterised TICK_DIV counter with a synchronous clear input and a tick output.
- Window mux, FSM and buffer live in `msg_scroller`.

## Test plan
All scenarios use TICK_DIV=4 and HOLD_STEPS=2 unless noted.
- Reset: hold rst_n low, then release → instruction = 40'hFFFFFFFFFF, load_ready=1, busy=0; no change after 100 cycles.
- Static load: len=3, chars 1,2,3 → at N+2 instruction = {1,2,3,1F×5}; busy=0; no change over 50 cycles.
- Scroll: len=10, chars 0..9 → window {0..7} held 8 cycles. It then steps each 4 cycles: {1..8}, {2..9}, {3..9,1F}, and so on. After 18 steps it returns to {0..7} with `wrap`=1 for exactly one cycle.
- Reload mid-scroll: during step 5, load len=2 {7,7} → no stale window after LOAD; instruction = {7,7,1F×6}; busy drops at N+2.
- Edge lengths:
  - len=0 → IDLE, all blanks.
  - len=31 with MSG_LEN=16 → saturates to 16 and L=24.
  - len=8 → STATIC, no wrap ever.
- Async reset mid-HOLD: rst_n pulsed low between clk edges → outputs reach reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/disp_pkg.sv
// Character and state definitions shared by the scroller and the seven-segment display driver.
// Holds only constants and types; it has no timing or flow-control behaviour of its own.
// Characters are CHAR_W-bit codes, and CHAR_BLANK switches a digit off.
package disp_pkg;

    localparam int CHAR_W     = 5;
    localparam int NUM_DIGITS = 8;
    localparam int WIN_W      = CHAR_W * NUM_DIGITS;

    localparam logic [CHAR_W-1:0] CHAR_BLANK = 5'h1F;

    localparam logic [CHAR_W-1:0] DIG_0 = 5'd0;
    localparam logic [CHAR_W-1:0] DIG_1 = 5'd1;
    localparam logic [CHAR_W-1:0] DIG_2 = 5'd2;
    localparam logic [CHAR_W-1:0] DIG_3 = 5'd3;
    localparam logic [CHAR_W-1:0] DIG_4 = 5'd4;
    localparam logic [CHAR_W-1:0] DIG_5 = 5'd5;
    localparam logic [CHAR_W-1:0] DIG_6 = 5'd6;
    localparam logic [CHAR_W-1:0] DIG_7 = 5'd7;
    localparam logic [CHAR_W-1:0] DIG_8 = 5'd8;
    localparam logic [CHAR_W-1:0] DIG_9 = 5'd9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_STATIC,
        ST_HOLD,
        ST_SCROLL
    } scr_state_e;

endpackage

// File: rtl/scroll_tick.sv
// Scroll step strobe: a free-running modulo-TICK_DIV counter that pulses tick_o on its last count.
// tick_o is combinational from the count and is high for exactly one cycle out of every TICK_DIV.
// clr_i restarts the count from zero and masks the tick in that cycle; there is no backpressure.
module scroll_tick #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr_i,
    output logic tick_o
);

    localparam int CW = $clog2(TICK_DIV);
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (clr_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    assign tick_o = !clr_i && (cnt_q == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/msg_scroller.sv
// Feeds the 8-digit display: shows a short message in place, or scrolls a longer one in a loop.
// A load handshake is followed by one LOAD cycle; the new window appears on instruction one cycle later.
// load_ready is low only during LOAD; the display output itself has no backpressure.
module msg_scroller
    import disp_pkg::*;
#(
    parameter int MSG_LEN    = 16,
    parameter int TICK_DIV   = 50_000_000,
    parameter int HOLD_STEPS = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHAR_W*MSG_LEN-1:0] msg_in,
    input  logic [4:0]                msg_len,
    input  logic                      load_valid,
    output logic                      load_ready,
    output logic [WIN_W-1:0]          instruction,
    output logic                      busy,
    output logic                      wrap
);

    localparam int HW = (HOLD_STEPS > 1) ? $clog2(HOLD_STEPS) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_STEPS - 1);

    scr_state_e        state_q, state_d;
    logic [CHAR_W-1:0] buf_q [MSG_LEN];
    logic [5:0]        len_q, len_sat, span, p_q, p_d, p_inc, idx;
    logic [HW-1:0]     hold_q, hold_d;
    logic [WIN_W-1:0]  instr_q, instr_d;
    logic              busy_q, busy_d, wrap_q, wrap_d;
    logic              hs, tick, tick_clr;
    logic [CHAR_W-1:0] ch;

    assign load_ready  = (state_q != ST_LOAD);
    assign hs          = load_valid && load_ready;
    assign instruction = instr_q;
    assign busy        = busy_q;
    assign wrap        = wrap_q;
    assign tick_clr    = (state_q == ST_LOAD);

    assign len_sat = ({1'b0, msg_len} > 6'(MSG_LEN)) ? 6'(MSG_LEN) : {1'b0, msg_len};
    // The message is followed by eight blanks before it repeats.
    assign span    = len_q + 6'd8;
    assign p_inc   = ((p_q + 6'd1) == span) ? 6'd0 : p_q + 6'd1;

    scroll_tick #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr_i  (tick_clr),
        .tick_o (tick)
    );

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        hold_d  = hold_q;
        wrap_d  = 1'b0;
        if (hs) begin
            state_d = ST_LOAD;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    p_d    = '0;
                    hold_d = '0;
                    if (len_q == 6'd0)       state_d = ST_IDLE;
                    else if (len_q <= 6'd8)  state_d = ST_STATIC;
                    else                     state_d = ST_HOLD;
                end
                ST_HOLD: begin
                    // The final hold tick is also the first scroll step.
                    if (tick) begin
                        if (hold_q == HOLD_LAST) begin
                            hold_d  = '0;
                            p_d     = p_inc;
                            state_d = ST_SCROLL;
                        end else begin
                            hold_d = hold_q + 1'b1;
                        end
                    end
                end
                ST_SCROLL: begin
                    if (tick) begin
                        p_d = p_inc;
                        if (p_inc == 6'd0) begin
                            wrap_d  = 1'b1;
                            state_d = ST_HOLD;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // The LOAD cycle keeps the previous frame; the new window shows once LOAD has resolved.
    always_comb begin
        instr_d = instr_q;
        busy_d  = busy_q;
        idx     = '0;
        ch      = CHAR_BLANK;
        if (state_d != ST_LOAD) begin
            busy_d = (state_d == ST_HOLD) || (state_d == ST_SCROLL);
            for (int k = 0; k < NUM_DIGITS; k++) begin
                idx = p_d + 6'(k);
                if (idx >= span) begin
                    idx = idx - span;
                end
                ch = CHAR_BLANK;
                if (state_d != ST_IDLE) begin
                    for (int j = 0; j < MSG_LEN; j++) begin
                        if ((idx == 6'(j)) && (idx < len_q)) begin
                            ch = buf_q[j];
                        end
                    end
                end
                instr_d[(NUM_DIGITS-1-k)*CHAR_W +: CHAR_W] = ch;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            p_q     <= '0;
            hold_q  <= '0;
            len_q   <= '0;
            instr_q <= '1;
            busy_q  <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            hold_q  <= hold_d;
            instr_q <= instr_d;
            busy_q  <= busy_d;
            wrap_q  <= wrap_d;
            if (hs) begin
                len_q <= len_sat;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (hs) begin
            for (int i = 0; i < MSG_LEN; i++) begin
                buf_q[i] <= msg_in[i*CHAR_W +: CHAR_W];
            end
        end
    end

endmodule

// File: tb/tb_msg_scroller.sv
// Checks msg_scroller against a cycle-count model built from its display rules, plus fixed expected windows.
module tb_msg_scroller;

    localparam int ML = 16;
    localparam int TD = 4;
    localparam int HS = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [79:0]   msg_in = '0;
    logic [4:0]    msg_len = '0;
    logic          load_valid = 1'b0;
    logic          load_ready, busy, wrap;
    logic [39:0]   instruction;

    int n_cmp = 0;
    int n_bad = 0;

    bit            m_load;
    int            m_len, m_t;
    logic [4:0]    m_msg [ML];
    logic [39:0]   e_instr;
    logic          e_busy, e_wrap, e_ready;

    always #5 clk = ~clk;

    msg_scroller #(
        .MSG_LEN    (ML),
        .TICK_DIV   (TD),
        .HOLD_STEPS (HS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .msg_in      (msg_in),
        .msg_len     (msg_len),
        .load_valid  (load_valid),
        .load_ready  (load_ready),
        .instruction (instruction),
        .busy        (busy),
        .wrap        (wrap)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Window at scroll position p: digit k shows S[(p+k) mod (len+8)].
    function automatic logic [39:0] model_win(int p);
        logic [39:0] r;
        int          l;
        int          idx;
        r = '1;
        l = m_len + 8;
        for (int k = 0; k < 8; k++) begin
            idx = (p + k) % l;
            r[(7-k)*5 +: 5] = (idx < m_len) ? m_msg[idx] : 5'h1F;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_load  = 1'b0;
        m_len   = 0;
        m_t     = 0;
        e_instr = '1;
        e_busy  = 1'b0;
        e_wrap  = 1'b0;
        e_ready = 1'b1;
    endtask

    // m_t counts cycles since LOAD; one loop is HS*TD cycles at p=0, then (L-1) steps of TD cycles.
    initial begin
        int per, u, p;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                model_reset();
            end else begin
                if (load_valid && !m_load) begin
                    m_load = 1'b1;
                    m_len  = (int'(msg_len) > ML) ? ML : int'(msg_len);
                    for (int i = 0; i < ML; i++) m_msg[i] = msg_in[i*5 +: 5];
                end else if (m_load) begin
                    m_load = 1'b0;
                    m_t    = 1;
                end else begin
                    m_t++;
                end
                e_wrap = 1'b0;
                if (m_load) begin
                    e_ready = 1'b0;
                end else begin
                    e_ready = 1'b1;
                    if (m_len == 0) begin
                        e_instr = '1;
                        e_busy  = 1'b0;
                    end else if (m_len <= 8) begin
                        e_instr = model_win(0);
                        e_busy  = 1'b0;
                    end else begin
                        per     = HS*TD + (m_len + 7)*TD;
                        u       = (m_t - 1) % per;
                        p       = (u < HS*TD) ? 0 : 1 + (u - HS*TD) / TD;
                        e_instr = model_win(p);
                        e_busy  = 1'b1;
                        e_wrap  = (m_t > 1) && (u == 0);
                    end
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            chk("cycle", 64'({instruction, busy, wrap, load_ready}),
                64'({e_instr, e_busy, e_wrap, e_ready}));
        end
    end

    function automatic logic [79:0] ramp(int base, int step);
        logic [79:0] r;
        for (int i = 0; i < 16; i++) r[i*5 +: 5] = 5'(base + step*i);
        return r;
    endfunction

    task automatic skip(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Leaves the caller at the sampling point of the LOAD cycle (N+1).
    task automatic do_load(input int len, input logic [79:0] m);
        @(negedge clk);
        msg_in     = m;
        msg_len    = 5'(len);
        load_valid = 1'b1;
        @(negedge clk);
        load_valid = 1'b0;
        chk("ready_in_load", 64'(load_ready), 64'(0));
    endtask

    initial begin
        int          vcnt;
        logic [95:0] rnd;
        vcnt = 0;

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_instr", 64'(instruction), 64'(40'hFFFFFFFFFF));
        chk("rst_ready", 64'(load_ready), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        skip(100);
        chk("rst_hold", 64'(instruction), 64'(40'hFFFFFFFFFF));

        do_load(3, ramp(1, 1));
        skip(1);
        chk("static3", 64'(instruction), 64'({5'd1, 5'd2, 5'd3, {5{5'h1F}}}));
        chk("static3_busy", 64'(busy), 64'(0));
        skip(50);
        chk("static3_hold", 64'(instruction), 64'({5'd1, 5'd2, 5'd3, {5{5'h1F}}}));

        do_load(10, ramp(0, 1));
        skip(1);
        chk("scr_w0", 64'(instruction), 64'({5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7}));
        chk("scr_busy", 64'(busy), 64'(1));
        skip(7);
        chk("scr_w0_end", 64'(instruction), 64'({5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7}));
        skip(1);
        chk("scr_w1", 64'(instruction), 64'({5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8}));
        skip(4);
        chk("scr_w2", 64'(instruction), 64'({5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9}));
        skip(4);
        chk("scr_w3", 64'(instruction), 64'({5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'h1F}));
        skip(60);
        chk("wrap_win", 64'(instruction), 64'({5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7}));
        chk("wrap_pulse", 64'(wrap), 64'(1));
        skip(1);
        chk("wrap_end", 64'(wrap), 64'(0));

        do_load(10, ramp(0, 1));
        skip(25);
        do_load(2, ramp(7, 0));
        chk("reload_busy_load", 64'(busy), 64'(1));
        skip(1);
        chk("reload_win", 64'(instruction), 64'({5'd7, 5'd7, {6{5'h1F}}}));
        chk("reload_busy", 64'(busy), 64'(0));

        do_load(0, ramp(3, 1));
        skip(1);
        chk("len0_win", 64'(instruction), 64'(40'hFFFFFFFFFF));
        chk("len0_busy", 64'(busy), 64'(0));

        do_load(31, ramp(0, 1));
        skip(69);
        chk("sat_p16", 64'(instruction), 64'(40'hFFFFFFFFFF));
        skip(4);
        chk("sat_p17", 64'(instruction), 64'({{7{5'h1F}}, 5'd0}));

        do_load(8, ramp(10, 1));
        skip(1);
        chk("len8_win", 64'(instruction),
            64'({5'd10, 5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd16, 5'd17}));
        chk("len8_busy", 64'(busy), 64'(0));
        skip(100);

        do_load(12, ramp(2, 1));
        skip(4);
        chk("hold_busy", 64'(busy), 64'(1));
        #2 rst_n = 1'b0;
        #1;
        chk("arst_instr", 64'(instruction), 64'(40'hFFFFFFFFFF));
        chk("arst_busy", 64'(busy), 64'(0));
        chk("arst_ready", 64'(load_ready), 64'(1));
        chk("arst_wrap", 64'(wrap), 64'(0));
        @(negedge clk);
        #2 rst_n = 1'b1;

        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if ((vcnt == 0) && ($urandom_range(0, 119) == 0)) begin
                vcnt    = $urandom_range(1, 3);
                rnd     = {$urandom(), $urandom(), $urandom()};
                msg_in  = rnd[79:0];
                msg_len = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 8))
                                                      : 5'($urandom_range(9, 31));
            end
            load_valid = (vcnt > 0);
            if (vcnt > 0) vcnt--;
        end
        load_valid = 1'b0;
        skip(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
